iir_biquad_mc: RTL and testbench

Time-multiplexed, multi-channel second-order IIR (biquad) section with run-time programmable coefficients, rounding/saturation and a valid/ready input handshake. It generalises the single-channel notch filter: one shared multiplier serves `NUM_CH` independent channel histories, and it sits between the modulator loop-filter stage and the DEM switch block. Default coefficients make the block a unity passthrough. Notch, DC-block or resonator responses are loaded through the coefficient port.

---
 rtl/lib_switchblock_pkg.sv | 21 ++
 rtl/iir_round_sat.sv | 36 +++
 rtl/iir_biquad_mc.sv | 180 ++++++++++++++++++
 tb/tb_iir_biquad_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// rtl/lib_switchblock_pkg.sv - shared types for the switch-block filter stages
package lib_switchblock_pkg;

  typedef enum logic [2:0] {
    TAP_B0 = 3'd0,
    TAP_B1 = 3'd1,
    TAP_B2 = 3'd2,
    TAP_A1 = 3'd3,
    TAP_A2 = 3'd4
  } biquad_tap_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } biquad_state_e;

  // Taps that reset to 1.0 (bit index = biquad_tap_e); only b0 gives a unity passthrough.
  localparam logic [4:0] BIQUAD_UNITY = 5'b00001;

endpackage

// File: rtl/iir_round_sat.sv
// rtl/iir_round_sat.sv - round-half-up and clamp a wide accumulator to a sample
module iir_round_sat #(
  parameter int ACC_W  = 37,
  parameter int FRAC_W = 16,
  parameter int DATA_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     sat_o
);

  // One extra bit so the rounding constant can never wrap the sum.
  localparam int SUM_W = ACC_W + 1;
  localparam int SH_W  = SUM_W - FRAC_W;

  localparam logic signed [SH_W-1:0] MAX_V = {{(SH_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SH_W-1:0] MIN_V = {{(SH_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [SUM_W-1:0] sum;
  logic signed [SH_W-1:0]  shifted;

  always_comb begin
    sum     = {acc_i[ACC_W-1], acc_i} + (SUM_W'(1) << (FRAC_W - 1));
    shifted = SH_W'(sum >>> FRAC_W);
    sat_o   = 1'b0;
    data_o  = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      sat_o  = 1'b1;
      data_o = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      sat_o  = 1'b1;
      data_o = MIN_V[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// rtl/iir_biquad_mc.sv - time-multiplexed multi-channel biquad with one shared multiplier
module iir_biquad_mc
  import lib_switchblock_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 16,
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ACC_W = DATA_W + COEF_W + 3
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CH_W-1:0]   in_ch_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              bypass_i,
  input  logic              state_clr_i,
  input  logic              coef_we_i,
  input  logic [2:0]        coef_sel_i,
  input  logic [COEF_W-1:0] coef_data_i,
  output logic              out_valid_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sat_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC_W;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  biquad_state_e state_q, state_d;
  biquad_tap_e   tap_q, tap_d;
  logic                     ready_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] x_q;
  logic                     byp_q;
  logic                     drop_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic signed [COEF_W-1:0] coef_q [5];
  logic signed [DATA_W-1:0] x1_q [NUM_CH];
  logic signed [DATA_W-1:0] x2_q [NUM_CH];
  logic signed [DATA_W-1:0] y1_q [NUM_CH];
  logic signed [DATA_W-1:0] y2_q [NUM_CH];

  logic                     out_valid_q;
  logic [CH_W-1:0]          out_ch_q;
  logic [DATA_W-1:0]        out_data_q;
  logic                     out_sat_q;

  logic                     accept;
  logic                     last_tap;
  logic [CH_W-1:0]          hidx;
  logic signed [DATA_W-1:0] opnd;
  logic signed [COEF_W-1:0] coef_m;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [DATA_W-1:0] y_rs, y_fin;
  logic                     sat_rs, sat_fin;

  assign accept   = ready_q && in_valid_i && !state_clr_i;
  assign last_tap = (state_q == MAC) && (tap_q == TAP_A2);

  always_comb begin
    hidx   = drop_q ? '0 : ch_q;
    opnd   = x_q;
    coef_m = coef_q[0];
    case (tap_q)
      TAP_B0:  begin opnd = x_q;        coef_m = coef_q[0]; end
      TAP_B1:  begin opnd = x1_q[hidx]; coef_m = coef_q[1]; end
      TAP_B2:  begin opnd = x2_q[hidx]; coef_m = coef_q[2]; end
      TAP_A1:  begin opnd = y1_q[hidx]; coef_m = coef_q[3]; end
      TAP_A2:  begin opnd = y2_q[hidx]; coef_m = coef_q[4]; end
      default: begin opnd = x_q;        coef_m = coef_q[0]; end
    endcase
    prod  = opnd * coef_m;
    term  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_d = (tap_q == TAP_A1 || tap_q == TAP_A2) ? acc_q - term : acc_q + term;
  end

  // Rounds the accumulator including the final tap, so the result registers on the edge into OUT.
  iir_round_sat #(
    .ACC_W (ACC_W),
    .FRAC_W(FRAC_W),
    .DATA_W(DATA_W)
  ) u_round_sat (
    .acc_i (acc_d),
    .data_o(y_rs),
    .sat_o (sat_rs)
  );

  assign y_fin   = byp_q ? x_q : y_rs;
  assign sat_fin = byp_q ? 1'b0 : sat_rs;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = MAC;
        tap_d   = TAP_B0;
      end
      MAC: begin
        if (tap_q == TAP_A2) state_d = OUT;
        else                 tap_d   = biquad_tap_e'(tap_q + 3'd1);
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_clr_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      tap_q       <= TAP_B0;
      ready_q     <= 1'b0;
      ch_q        <= '0;
      x_q         <= '0;
      byp_q       <= 1'b0;
      drop_q      <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < 5; i++) coef_q[i] <= BIQUAD_UNITY[i] ? COEF_ONE : '0;
      for (int i = 0; i < NUM_CH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      ready_q     <= (state_d == IDLE);
      out_valid_q <= 1'b0;

      if (accept) begin
        ch_q   <= in_ch_i;
        x_q    <= in_data_i;
        byp_q  <= bypass_i;
        drop_q <= ({1'b0, in_ch_i} >= NUM_CH_L);
        acc_q  <= '0;
      end else if (state_q == MAC) begin
        acc_q  <= acc_d;
      end

      if (ready_q && coef_we_i && coef_sel_i <= 3'd4) coef_q[coef_sel_i] <= coef_data_i;

      if (state_clr_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
          x1_q[i] <= '0;
          x2_q[i] <= '0;
          y1_q[i] <= '0;
          y2_q[i] <= '0;
        end
      end else if (last_tap && !drop_q) begin
        out_valid_q    <= 1'b1;
        out_ch_q       <= ch_q;
        out_data_q     <= y_fin;
        out_sat_q      <= sat_fin;
        x2_q[ch_q]     <= x1_q[ch_q];
        x1_q[ch_q]     <= x_q;
        y2_q[ch_q]     <= y1_q[ch_q];
        y1_q[ch_q]     <= y_fin;
      end
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb/tb_iir_biquad_mc.sv - directed-vector bench for iir_biquad_mc
module tb_iir_biquad_mc;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_data;
  logic               bypass;
  logic               state_clr;
  logic               coef_we;
  logic [2:0]         coef_sel;
  logic signed [17:0] coef_data;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               in_ready3;
  logic               out_valid3;
  logic [1:0]         out_ch3;
  logic signed [15:0] out_data3;
  logic               out_sat3;

  int n_vec = 0;
  int n_err = 0;
  int ry, rsat, rch, rlat, rrdy1, rrdy6, rrdy7, rv3, ry3;

  always #5 clk = ~clk;

  iir_biquad_mc u_dut (
    .clk_i(clk), .reset_ni(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ch_i(in_ch), .in_data_i(in_data),
    .bypass_i(bypass), .state_clr_i(state_clr),
    .coef_we_i(coef_we), .coef_sel_i(coef_sel), .coef_data_i(coef_data),
    .out_valid_o(out_valid), .out_ch_o(out_ch), .out_data_o(out_data), .out_sat_o(out_sat)
  );

  iir_biquad_mc #(.NUM_CH(3)) u_dut3 (
    .clk_i(clk), .reset_ni(reset_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready3), .in_ch_i(in_ch), .in_data_i(in_data),
    .bypass_i(bypass), .state_clr_i(state_clr),
    .coef_we_i(coef_we), .coef_sel_i(coef_sel), .coef_data_i(coef_data),
    .out_valid_o(out_valid3), .out_ch_o(out_ch3), .out_data_o(out_data3), .out_sat_o(out_sat3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input int sel, input int val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_sel  = 3'(sel);
    coef_data = 18'(val);
    @(posedge clk); #1;
    coef_we   = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    state_clr = 1'b1;
    @(posedge clk); #1;
    state_clr = 1'b0;
  endtask

  // ek>0 injects a mid-flight event at negedge ek: a clear (eclr) or a b0:=0 write.
  task automatic send(input int ch, input int x, input bit byp = 1'b0,
                      input bit we = 1'b0, input int sel = 0, input int cd = 0,
                      input int ek = 0, input bit eclr = 1'b0);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid  = 1'b1;
    in_ch     = 2'(ch);
    in_data   = 16'(x);
    bypass    = byp;
    coef_we   = we;
    coef_sel  = 3'(sel);
    coef_data = 18'(cd);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
    coef_we  = 1'b0;
    ry = 0; rsat = -1; rch = -1; rlat = -1; rv3 = 0; ry3 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) rrdy1 = int'(in_ready);
      if (k == 6) rrdy6 = int'(in_ready);
      if (k == 7) rrdy7 = int'(in_ready);
      if (out_valid3) begin
        rv3 = 1;
        ry3 = int'(out_data3);
      end
      if (out_valid && rlat < 0) begin
        rlat = k;
        ry   = int'(out_data);
        rsat = int'(out_sat);
        rch  = int'(out_ch);
      end
      if (ek != 0 && k == ek) begin
        if (eclr) state_clr = 1'b1;
        else begin
          coef_we = 1'b1; coef_sel = 3'd0; coef_data = '0;
        end
      end
      if (ek != 0 && k == ek + 1) begin
        state_clr = 1'b0;
        coef_we   = 1'b0;
      end
    end
  endtask

  initial begin
    int imp_exp[5];
    int imp_in[5];
    int dc_exp[4];
    imp_in  = '{1000, 0, 0, 0, 0};
    imp_exp = '{1000, 500, 250, 125, 63};
    dc_exp  = '{1000, -1000, 0, 0};

    reset_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0; bypass = 1'b0;
    state_clr = 1'b0; coef_we = 1'b0; coef_sel = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_rise", int'(in_ready), 1);

    send(0, 1234);
    chk("pass_data", ry, 1234);
    chk("pass_ch", rch, 0);
    chk("pass_sat", rsat, 0);
    chk("pass_lat", rlat, 6);
    chk("busy_rdy1", rrdy1, 0);
    chk("busy_rdy6", rrdy6, 0);
    chk("rdy_back", rrdy7, 1);
    chk("dut3_pass", ry3, 1234);

    clr();
    wcoef(3, -32768);
    for (int i = 0; i < 5; i++) begin
      send(0, imp_in[i]);
      chk($sformatf("impulse_%0d", i), ry, imp_exp[i]);
    end

    clr();
    wcoef(1, -131072);
    wcoef(2, 65536);
    wcoef(3, 0);
    for (int i = 0; i < 4; i++) begin
      send(0, 1000);
      chk($sformatf("notch_%0d", i), ry, dc_exp[i]);
    end

    clr();
    wcoef(0, 131071);
    wcoef(1, 0);
    wcoef(2, 0);
    send(0, 30000);
    chk("sat_pos", ry, 32767);
    chk("sat_pos_f", rsat, 1);
    send(0, -30000);
    chk("sat_neg", ry, -32768);
    chk("sat_neg_f", rsat, 1);
    send(0, 0);
    chk("sat_zero", ry, 0);
    chk("sat_zero_f", rsat, 0);

    clr();
    wcoef(0, 65536);
    wcoef(3, -32768);
    for (int i = 0; i < 3; i++) begin
      send(1, imp_in[i]);
      chk($sformatf("iso_ch1_%0d", i), ry, imp_exp[i]);
      chk($sformatf("iso_ch1_id_%0d", i), rch, 1);
      send(2, 0);
      chk($sformatf("iso_ch2_%0d", i), ry, 0);
      chk($sformatf("iso_ch2_id_%0d", i), rch, 2);
    end

    send(1, 777, 1'b1);
    chk("byp_data", ry, 777);
    chk("byp_sat", rsat, 0);
    send(1, 0);
    chk("byp_hist", ry, 389);

    send(3, 500);
    chk("ch3_dut4", ry, 500);
    chk("ch3_drop3", rv3, 0);

    clr();
    send(0, 1000);
    chk("pre_abort", ry, 1000);
    send(0, 1000, 1'b0, 1'b0, 0, 0, 3, 1'b1);
    chk("abort_nov", rlat, -1);
    send(0, 0);
    chk("post_abort", ry, 0);

    send(2, 100, 1'b0, 1'b0, 0, 0, 2, 1'b0);
    chk("busy_we_cur", ry, 100);
    send(3, 200);
    chk("busy_we_next", ry, 200);

    send(1, 300, 1'b0, 1'b1, 0, 98304);
    chk("same_cyc_we", ry, 450);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
